// File: rtl/memory_access.sv
// memory_access: MEM stage of the 5-stage MIPS pipeline.
// Holds the word-organised data memory with byte/half/word stores and
// signed/unsigned loads, and registers the MEM/WB pipeline outputs.
// Optional feature macro: MEM_MISALIGN_TRAP_EN. When it is defined,
// misaligned half/word accesses are trapped. When it is undefined,
// alignment offsets are ignored and o_misaligned is tied low.
module memory_access #(
    parameter int ADDR_W  = 8,
    parameter int NB_DATA = 32,
    parameter int NB_REG  = 5
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_enable,
    input  logic               i_WB_write,
    input  logic               i_WB_mem_to_reg,
    input  logic               i_MEM_read,
    input  logic               i_MEM_write,
    input  logic               i_MEM_unsigned,
    input  logic [1:0]         i_MEM_byte_half_word,
    input  logic [NB_DATA-1:0] i_ALU_result,
    input  logic [NB_DATA-1:0] i_data_to_write_in_MEM,
    input  logic [NB_REG-1:0]  i_write_reg,
    input  logic [ADDR_W-1:0]  i_debug_addr,
    output logic               o_WB_write,
    output logic               o_WB_mem_to_reg,
    output logic [NB_DATA-1:0] o_read_data,
    output logic [NB_DATA-1:0] o_ALU_result,
    output logic [NB_REG-1:0]  o_write_reg,
    output logic [NB_DATA-1:0] o_debug_data,
    output logic               o_misaligned
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [NB_DATA-1:0] mem [DEPTH];

    logic [ADDR_W-1:0]  word_idx;
    logic [1:0]         byte_off;
    logic               is_byte;
    logic               is_half;
    logic               misaligned;
    logic [3:0]         byte_en;
    logic [NB_DATA-1:0] store_data;
    logic [NB_DATA-1:0] mem_word;
    logic [7:0]         load_byte;
    logic [15:0]        load_half;
    logic [NB_DATA-1:0] load_ext;
    logic               unused_alu_upper;

    logic               wb_write_d,    wb_write_q;
    logic               mem_to_reg_d,  mem_to_reg_q;
    logic [NB_DATA-1:0] read_data_d,   read_data_q;
    logic [NB_DATA-1:0] alu_result_d,  alu_result_q;
    logic [NB_REG-1:0]  write_reg_d,   write_reg_q;
    logic [NB_DATA-1:0] debug_data_d,  debug_data_q;

    // Upper address bits wrap: they select nothing inside this memory.
    assign word_idx         = i_ALU_result[ADDR_W+1:2];
    assign byte_off         = i_ALU_result[1:0];
    assign unused_alu_upper = &{1'b0, i_ALU_result[NB_DATA-1:ADDR_W+2]};
    assign is_byte          = (i_MEM_byte_half_word == 2'b00);
    assign is_half          = (i_MEM_byte_half_word == 2'b01);
    assign mem_word         = mem[word_idx];

    // Decide whether the current access breaks natural alignment.
    always_comb begin
        misaligned = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
        if ((i_MEM_read | i_MEM_write) & i_enable) begin
            if (is_half)
                misaligned = byte_off[0];
            else if (!is_byte)
                misaligned = (byte_off != 2'b00);
        end
`endif
    end

    // Steer store data onto byte lanes and build the lane write mask.
    always_comb begin
        byte_en    = 4'b0000;
        store_data = i_data_to_write_in_MEM;
        if (is_byte) begin
            byte_en[byte_off] = 1'b1;
            store_data        = {4{i_data_to_write_in_MEM[7:0]}};
        end else if (is_half) begin
            byte_en    = byte_off[1] ? 4'b1100 : 4'b0011;
            store_data = {2{i_data_to_write_in_MEM[15:0]}};
        end else begin
            byte_en = 4'b1111;
        end
        if (!(i_MEM_write & i_enable & !i_reset & !misaligned))
            byte_en = 4'b0000;
    end

    // Data memory array, written lane by lane, never cleared by reset.
    always_ff @(posedge i_clk) begin
        for (int k = 0; k < 4; k++) begin
            if (byte_en[k])
                mem[word_idx][8*k +: 8] <= store_data[8*k +: 8];
        end
    end

    // Extract the addressed byte or halfword and extend it to 32 bits.
    always_comb begin
        load_byte = 8'h00;
        case (byte_off)
            2'd0: load_byte = mem_word[7:0];
            2'd1: load_byte = mem_word[15:8];
            2'd2: load_byte = mem_word[23:16];
            2'd3: load_byte = mem_word[31:24];
            default: load_byte = 8'h00;
        endcase
        load_half = byte_off[1] ? mem_word[31:16] : mem_word[15:0];
        if (is_byte)
            load_ext = i_MEM_unsigned ? {24'h000000, load_byte}
                                      : {{24{load_byte[7]}}, load_byte};
        else if (is_half)
            load_ext = i_MEM_unsigned ? {16'h0000, load_half}
                                      : {{16{load_half[15]}}, load_half};
        else
            load_ext = mem_word;
    end

    // Next values of the MEM/WB register; the debug port ignores the freeze.
    always_comb begin
        wb_write_d   = wb_write_q;
        mem_to_reg_d = mem_to_reg_q;
        read_data_d  = read_data_q;
        alu_result_d = alu_result_q;
        write_reg_d  = write_reg_q;
        debug_data_d = mem[i_debug_addr];
        if (i_enable) begin
            wb_write_d   = i_WB_write & !misaligned;
            mem_to_reg_d = i_WB_mem_to_reg;
            read_data_d  = (i_MEM_read & !misaligned) ? load_ext : '0;
            alu_result_d = i_ALU_result;
            write_reg_d  = i_write_reg;
        end
    end

    // MEM/WB pipeline register with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wb_write_q   <= 1'b0;
            mem_to_reg_q <= 1'b0;
            read_data_q  <= '0;
            alu_result_q <= '0;
            write_reg_q  <= '0;
            debug_data_q <= '0;
        end else begin
            wb_write_q   <= wb_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            read_data_q  <= read_data_d;
            alu_result_q <= alu_result_d;
            write_reg_q  <= write_reg_d;
            debug_data_q <= debug_data_d;
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    logic misaligned_d, misaligned_q;

    // Sticky trap flag: once set it stays set until reset.
    always_comb begin
        misaligned_d = misaligned_q | misaligned;
    end

    // Trap flag register with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset)
            misaligned_q <= 1'b0;
        else
            misaligned_q <= misaligned_d;
    end

    assign o_misaligned = misaligned_q;
`else
    assign o_misaligned = 1'b0;
`endif

    assign o_WB_write      = wb_write_q;
    assign o_WB_mem_to_reg = mem_to_reg_q;
    assign o_read_data     = read_data_q;
    assign o_ALU_result    = alu_result_q;
    assign o_write_reg     = write_reg_q;
    assign o_debug_data    = debug_data_q;

endmodule

// File: tb/tb_memory_access.sv
// Testbench for memory_access: directed table, hand-written corner sequences
// and randomized traffic checked against a byte-addressed reference model.
module tb_memory_access;

    localparam int ADDR_W = 8;
    localparam int BYTES  = 4 << ADDR_W;

    logic              i_clk;
    logic              i_reset;
    logic              i_enable;
    logic              i_WB_write;
    logic              i_WB_mem_to_reg;
    logic              i_MEM_read;
    logic              i_MEM_write;
    logic              i_MEM_unsigned;
    logic [1:0]        i_MEM_byte_half_word;
    logic [31:0]       i_ALU_result;
    logic [31:0]       i_data_to_write_in_MEM;
    logic [4:0]        i_write_reg;
    logic [ADDR_W-1:0] i_debug_addr;
    logic              o_WB_write;
    logic              o_WB_mem_to_reg;
    logic [31:0]       o_read_data;
    logic [31:0]       o_ALU_result;
    logic [4:0]        o_write_reg;
    logic [31:0]       o_debug_data;
    logic              o_misaligned;

    memory_access #(.ADDR_W(ADDR_W), .NB_DATA(32), .NB_REG(5)) dut (
        .i_clk                  (i_clk),
        .i_reset                (i_reset),
        .i_enable               (i_enable),
        .i_WB_write             (i_WB_write),
        .i_WB_mem_to_reg        (i_WB_mem_to_reg),
        .i_MEM_read             (i_MEM_read),
        .i_MEM_write            (i_MEM_write),
        .i_MEM_unsigned         (i_MEM_unsigned),
        .i_MEM_byte_half_word   (i_MEM_byte_half_word),
        .i_ALU_result           (i_ALU_result),
        .i_data_to_write_in_MEM (i_data_to_write_in_MEM),
        .i_write_reg            (i_write_reg),
        .i_debug_addr           (i_debug_addr),
        .o_WB_write             (o_WB_write),
        .o_WB_mem_to_reg        (o_WB_mem_to_reg),
        .o_read_data            (o_read_data),
        .o_ALU_result           (o_ALU_result),
        .o_write_reg            (o_write_reg),
        .o_debug_data           (o_debug_data),
        .o_misaligned           (o_misaligned)
    );

    typedef struct {
        logic        rst, en, wb, m2r, rd, wr, uns;
        logic [1:0]  bhw;
        logic [31:0] alu, wdata;
        logic [4:0]  wreg;
        logic [7:0]  dbg;
        logic [31:0] exp_rd, exp_dbg;
    } vec_t;

    // Reference model state: memory as a flat little-endian byte array.
    logic [7:0]  ref_bytes [BYTES];
    logic        exp_wb, exp_m2r, exp_mis;
    logic [31:0] exp_rd, exp_alu, exp_dbg;
    logic [4:0]  exp_wreg;

    int check_count = 0;
    int pass_count  = 0;

    vec_t tbl [14];
    vec_t v;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic logic [31:0] refWord(input int base);
        return {ref_bytes[base+3], ref_bytes[base+2], ref_bytes[base+1], ref_bytes[base]};
    endfunction

    function automatic vec_t mk(input logic wb, input logic rd, input logic wr,
                                input logic uns, input logic [1:0] bhw,
                                input logic [31:0] alu, input logic [31:0] wdata,
                                input logic [4:0] wreg, input logic [7:0] dbg,
                                input logic [31:0] exp_r, input logic [31:0] exp_d);
        vec_t r;
        r.rst = 1'b0; r.en = 1'b1; r.wb = wb; r.m2r = rd; r.rd = rd; r.wr = wr;
        r.uns = uns; r.bhw = bhw; r.alu = alu; r.wdata = wdata; r.wreg = wreg;
        r.dbg = dbg; r.exp_rd = exp_r; r.exp_dbg = exp_d;
        return r;
    endfunction

    // Expected next outputs from the access rules, then apply any store.
    task automatic modelStep(input vec_t s);
        int a, base;
        logic [31:0] ld, dbg_word;
        logic mis;
        dbg_word = refWord(int'(s.dbg) * 4);
        if (s.rst) begin
            exp_wb = 0; exp_m2r = 0; exp_rd = 0; exp_alu = 0; exp_wreg = 0;
            exp_dbg = 0; exp_mis = 0;
            return;
        end
        exp_dbg = dbg_word;
        if (!s.en) return;
        a = int'(s.alu % BYTES);
        if (s.bhw == 2'b00)      base = a;
        else if (s.bhw == 2'b01) base = a - (a % 2);
        else                     base = a - (a % 4);
        mis = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
        if ((s.rd || s.wr) && base != a) mis = 1'b1;
`endif
        if (s.bhw == 2'b00) begin
            ld = 32'(ref_bytes[a]);
            if (!s.uns && ld >= 32'h80) ld = ld | 32'hFFFFFF00;
        end else if (s.bhw == 2'b01) begin
            ld = 32'(ref_bytes[base]) + 32'(ref_bytes[base+1]) * 256;
            if (!s.uns && ld >= 32'h8000) ld = ld | 32'hFFFF0000;
        end else begin
            ld = refWord(base);
        end
        exp_rd   = (s.rd && !mis) ? ld : 32'h0;
        exp_wb   = s.wb && !mis;
        exp_m2r  = s.m2r;
        exp_alu  = s.alu;
        exp_wreg = s.wreg;
        if (mis) exp_mis = 1'b1;
        if (s.wr && !mis) begin
            ref_bytes[base] = s.wdata[7:0];
            if (s.bhw != 2'b00) ref_bytes[base+1] = s.wdata[15:8];
            if (s.bhw[1]) begin
                ref_bytes[base+2] = s.wdata[23:16];
                ref_bytes[base+3] = s.wdata[31:24];
            end
        end
    endtask

    // Drive one cycle of inputs away from the edge, advance the model, sample after the edge.
    task automatic applyStimulus(input vec_t s);
        @(negedge i_clk);
        i_reset = s.rst; i_enable = s.en; i_WB_write = s.wb; i_WB_mem_to_reg = s.m2r;
        i_MEM_read = s.rd; i_MEM_write = s.wr; i_MEM_unsigned = s.uns;
        i_MEM_byte_half_word = s.bhw; i_ALU_result = s.alu;
        i_data_to_write_in_MEM = s.wdata; i_write_reg = s.wreg; i_debug_addr = s.dbg;
        modelStep(s);
        @(posedge i_clk);
        #1;
    endtask

    task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
        check_count++;
        if (act === exp) pass_count++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, " wb_write"},   32'(o_WB_write),      32'(exp_wb));
        checkOutput({tag, " mem_to_reg"}, 32'(o_WB_mem_to_reg), 32'(exp_m2r));
        checkOutput({tag, " read_data"},  o_read_data,          exp_rd);
        checkOutput({tag, " alu_result"}, o_ALU_result,         exp_alu);
        checkOutput({tag, " write_reg"},  32'(o_write_reg),     32'(exp_wreg));
        checkOutput({tag, " debug_data"}, o_debug_data,         exp_dbg);
        checkOutput({tag, " misaligned"}, 32'(o_misaligned),    32'(exp_mis));
    endtask

    initial begin
        for (int i = 0; i < BYTES; i++) ref_bytes[i] = 8'h00;
        exp_wb = 0; exp_m2r = 0; exp_rd = 0; exp_alu = 0; exp_wreg = 0; exp_dbg = 0; exp_mis = 0;

        // Reset with the stage frozen and a store pending: reset must still win.
        v = mk(1, 1, 1, 0, 2'b11, 32'h0000_0010, 32'hFFFF_FFFF, 5'd3, 8'd0, 0, 0);
        v.rst = 1'b1; v.en = 1'b0;
        applyStimulus(v);
        applyStimulus(v);
        checkAll("reset");

        // Fill every memory word with zero so later reads are defined.
        for (int i = 0; i < (1 << ADDR_W); i++)
            applyStimulus(mk(0, 0, 1, 0, 2'b11, 32'(i * 4), 32'h0, 5'd0, 8'd0, 0, 0));

        tbl[0]  = mk(0, 0, 1, 0, 2'b11, 32'h10, 32'hDEADBEEF, 5'd0, 8'd4,  32'h0,        32'h0);
        tbl[1]  = mk(1, 1, 0, 0, 2'b11, 32'h10, 32'h0,        5'd2, 8'd4,  32'hDEADBEEF, 32'hDEADBEEF);
        tbl[2]  = mk(0, 0, 1, 0, 2'b11, 32'h20, 32'h11223344, 5'd0, 8'd4,  32'h0,        32'hDEADBEEF);
        tbl[3]  = mk(0, 0, 1, 0, 2'b00, 32'h21, 32'h000000AA, 5'd0, 8'd4,  32'h0,        32'hDEADBEEF);
        tbl[4]  = mk(1, 1, 0, 0, 2'b11, 32'h20, 32'h0,        5'd4, 8'd8,  32'h1122AA44, 32'h1122AA44);
        tbl[5]  = mk(1, 1, 0, 0, 2'b00, 32'h21, 32'h0,        5'd5, 8'd4,  32'hFFFFFFAA, 32'hDEADBEEF);
        tbl[6]  = mk(1, 1, 0, 1, 2'b00, 32'h21, 32'h0,        5'd6, 8'd4,  32'h000000AA, 32'hDEADBEEF);
        tbl[7]  = mk(0, 0, 1, 0, 2'b11, 32'h30, 32'h0,        5'd0, 8'd4,  32'h0,        32'hDEADBEEF);
        tbl[8]  = mk(0, 0, 1, 0, 2'b01, 32'h32, 32'h00008001, 5'd0, 8'd4,  32'h0,        32'hDEADBEEF);
        tbl[9]  = mk(1, 1, 0, 0, 2'b11, 32'h30, 32'h0,        5'd7, 8'd12, 32'h80010000, 32'h80010000);
        tbl[10] = mk(1, 1, 0, 0, 2'b01, 32'h32, 32'h0,        5'd8, 8'd4,  32'hFFFF8001, 32'hDEADBEEF);
        tbl[11] = mk(1, 1, 0, 1, 2'b01, 32'h32, 32'h0,        5'd9, 8'd4,  32'h00008001, 32'hDEADBEEF);
        tbl[12] = mk(1, 1, 0, 0, 2'b01, 32'h30, 32'h0,        5'd10, 8'd4, 32'h00000000, 32'hDEADBEEF);
        tbl[13] = mk(1, 0, 0, 0, 2'b11, 32'h7,  32'h0,        5'd9, 8'd4,  32'h00000000, 32'hDEADBEEF);

        // Directed vectors with hand-derived expectations.
        for (int i = 0; i < 14; i++) begin
            applyStimulus(tbl[i]);
            checkOutput($sformatf("row%0d read_data", i),  o_read_data,       tbl[i].exp_rd);
            checkOutput($sformatf("row%0d debug_data", i), o_debug_data,      tbl[i].exp_dbg);
            checkOutput($sformatf("row%0d alu_result", i), o_ALU_result,      tbl[i].alu);
            checkOutput($sformatf("row%0d write_reg", i),  32'(o_write_reg),  32'(tbl[i].wreg));
            checkOutput($sformatf("row%0d wb_write", i),   32'(o_WB_write),   32'(tbl[i].wb));
        end

        // Freeze with a store pending: outputs hold, memory untouched, debug still live.
        v = mk(0, 0, 1, 0, 2'b11, 32'h40, 32'h55AA55AA, 5'd1, 8'd16, 0, 0);
        v.en = 1'b0;
        applyStimulus(v);
        checkOutput("freeze alu_hold", o_ALU_result, 32'h7);
        checkOutput("freeze wreg_hold", 32'(o_write_reg), 32'd9);
        checkOutput("freeze dbg", o_debug_data, 32'h0);
        applyStimulus(v);
        checkOutput("freeze mem_unchanged", o_debug_data, 32'h0);
        v.en = 1'b1;
        applyStimulus(v);
        checkOutput("unfreeze alu", o_ALU_result, 32'h40);
        checkOutput("unfreeze dbg_old", o_debug_data, 32'h0);
        applyStimulus(mk(0, 0, 0, 0, 2'b11, 32'h0, 32'h0, 5'd0, 8'd16, 0, 0));
        checkOutput("unfreeze dbg_new", o_debug_data, 32'h55AA55AA);

        // Reset coinciding with a store: store suppressed, outputs cleared.
        v = mk(1, 0, 1, 0, 2'b11, 32'h44, 32'h12345678, 5'd3, 8'd17, 0, 0);
        v.rst = 1'b1;
        applyStimulus(v);
        checkAll("reset_store");
        applyStimulus(mk(0, 0, 0, 0, 2'b11, 32'h0, 32'h0, 5'd0, 8'd17, 0, 0));
        checkOutput("reset_store mem_unchanged", o_debug_data, 32'h0);

        // Misaligned word store then load at 0x13.
        applyStimulus(mk(0, 0, 1, 0, 2'b11, 32'h13, 32'hCAFEF00D, 5'd0, 8'd4, 0, 0));
        applyStimulus(mk(1, 1, 0, 0, 2'b11, 32'h13, 32'h0, 5'd11, 8'd4, 0, 0));
`ifdef MEM_MISALIGN_TRAP_EN
        checkOutput("misalign mem", o_debug_data, 32'hDEADBEEF);
        checkOutput("misalign flag", 32'(o_misaligned), 32'd1);
        checkOutput("misalign rd", o_read_data, 32'h0);
        checkOutput("misalign wb", 32'(o_WB_write), 32'd0);
`else
        checkOutput("misalign mem", o_debug_data, 32'hCAFEF00D);
        checkOutput("misalign flag", 32'(o_misaligned), 32'd0);
        checkOutput("misalign rd", o_read_data, 32'hCAFEF00D);
        checkOutput("misalign wb", 32'(o_WB_write), 32'd1);
`endif
        checkAll("misalign");

        // Randomized traffic in a small address window against the model.
        for (int n = 0; n < 600; n++) begin
            v = mk(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom),
                   ($urandom & 32'hFFFFFC00) | 32'($urandom_range(0, 63)),
                   $urandom, 5'($urandom), 8'($urandom_range(0, 15)), 0, 0);
            v.m2r = 1'($urandom);
            v.en  = ($urandom_range(0, 7) != 0);
            v.rst = ($urandom_range(0, 79) == 0);
            applyStimulus(v);
            checkAll($sformatf("rand%0d", n));
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
